// File: rtl/sumador_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sumador_pkg
// Brief    : Shared types and helpers for the sumador_acumulador datapath:
//            operation encoding, handshake state, sign extension and the
//            saturation bounds used by the optional clamping build.
// Revision : 1.0 - initial release
// ============================================================================
package sumador_pkg;

    // Operation select; bit 1 marks accumulate ops, bit 0 marks subtraction.
    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ACC_ADD = 2'b10,
        OP_ACC_SUB = 2'b11
    } op_t;

    // Output register occupancy; the encoding doubles as out_valid.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Widest datapath the helpers below can describe.
    localparam int unsigned c_max_w = 64;

    // Two's complement image of an already sign-extended value, trimmed to
    // to_width bits (upper bits cleared). The caller supplies the value
    // sign-extended to c_max_w and truncates the result to its own width.
    function automatic logic [c_max_w-1:0] sext(input logic signed [c_max_w-1:0] value,
                                                input int unsigned             to_width);
        logic [c_max_w-1:0] mask;
        mask = (to_width >= c_max_w) ? '1 : ((c_max_w'(1) << to_width) - c_max_w'(1));
        return value & mask;
    endfunction

    // Largest positive value representable in w-bit two's complement.
    function automatic logic [c_max_w-1:0] sat_max(input int unsigned w);
        return (c_max_w'(1) << (w - 1)) - c_max_w'(1);
    endfunction

    // Bit pattern of the most negative w-bit two's complement value.
    function automatic logic [c_max_w-1:0] sat_min(input int unsigned w);
        return c_max_w'(1) << (w - 1);
    endfunction

endpackage : sumador_pkg
`default_nettype wire

// File: rtl/sumador_core.sv
`default_nettype none
// ============================================================================
// Module   : sumador_core
// Brief    : Combinational signed adder/subtractor with two's complement
//            overflow detection. Shared by every operation of the top level.
// Revision : 1.0 - initial release
// ============================================================================
module sumador_core #(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] x,
    input  logic [ACC_W-1:0] y,
    input  logic             sub,
    output logic [ACC_W-1:0] sum,
    output logic             overflow
);

    logic w_y_sign;

    // Sum/difference plus overflow: operands of equal effective sign giving
    // a result of the opposite sign. For subtraction the effective sign is
    // that of the negated operand.
    always_comb begin
        sum      = sub ? (x - y) : (x + y);
        w_y_sign = sub ? ~y[ACC_W-1] : y[ACC_W-1];
        overflow = (x[ACC_W-1] == w_y_sign) && (sum[ACC_W-1] != x[ACC_W-1]);
    end

endmodule : sumador_core
`default_nettype wire

// File: rtl/sumador_acumulador.sv
`default_nettype none
// ============================================================================
// Module   : sumador_acumulador
// Brief    : Registered signed add/sub unit with a running accumulator and a
//            one-deep valid/ready output stage (full throughput).
//            Build option: define SUMADOR_ACUMULADOR_SAT_EN to make the
//            accumulate ops saturate instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sumador_acumulador
    import sumador_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] c,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);

`ifdef SUMADOR_ACUMULADOR_SAT_EN
    localparam logic [ACC_W-1:0] c_sat_max = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] c_sat_min = ACC_W'(sat_min(ACC_W));
`endif

    state_t             r_state;
    state_t             w_state_next;
    logic [ACC_W-1:0]   r_c;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;

    logic               w_accept;
    logic               w_is_acc;
    logic               w_sub;
    logic [ACC_W-1:0]   w_a_ext;
    logic [ACC_W-1:0]   w_b_ext;
    logic [ACC_W-1:0]   w_acc_base;
    logic [ACC_W-1:0]   w_x;
    logic [ACC_W-1:0]   w_y;
    logic [ACC_W-1:0]   w_sum;
    logic               w_overflow;
    logic [ACC_W-1:0]   w_result;

    assign out_valid = (r_state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign c         = r_c;
    assign acc       = r_acc;
    assign ovf       = r_ovf;

    assign w_is_acc  = op[1];
    assign w_sub     = op[0];
    assign w_a_ext   = ACC_W'(sext(c_max_w'($signed(a)), ACC_W));
    assign w_b_ext   = ACC_W'(sext(c_max_w'($signed(b)), ACC_W));
    // A same-cycle clear is applied before accumulating.
    assign w_acc_base = clr ? '0 : r_acc;

    // Operand mux: plain ops use a/b, accumulate ops use the accumulator and a.
    always_comb begin
        w_x = w_a_ext;
        w_y = w_b_ext;
        if (w_is_acc) begin
            w_x = w_acc_base;
            w_y = w_a_ext;
        end
    end

    sumador_core #(
        .ACC_W    (ACC_W)
    ) u_core (
        .x        (w_x),
        .y        (w_y),
        .sub      (w_sub),
        .sum      (w_sum),
        .overflow (w_overflow)
    );

    // Result select; overflow direction follows the sign of the accumulator base.
    always_comb begin
        w_result = w_sum;
`ifdef SUMADOR_ACUMULADOR_SAT_EN
        if (w_is_acc && w_overflow) begin
            w_result = w_x[ACC_W-1] ? c_sat_min : c_sat_max;
        end
`endif
    end

    // Output stage occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next occupancy: fill on accept, drain when consumed with nothing new.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept)               w_state_next = ST_FULL;
            ST_FULL:  if (out_ready && !in_valid) w_state_next = ST_EMPTY;
            default:                              w_state_next = ST_EMPTY;
        endcase
    end

    // Result register loads on every accepted operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c <= '0;
        end else if (w_accept) begin
            r_c <= w_result;
        end
    end

    // Accumulator and sticky overflow; clear wins unless an accumulate op
    // is accepted, in which case it has already been folded into the base.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept && w_is_acc) begin
            r_acc <= w_result;
            r_ovf <= (r_ovf && !clr) || w_overflow;
        end else if (clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end
    end

endmodule : sumador_acumulador
`default_nettype wire

// File: tb/tb_sumador_acumulador.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sumador_acumulador
// Brief    : Scoreboard bench for sumador_acumulador (WIDTH=4, ACC_W=8).
//            Honours SUMADOR_ACUMULADOR_SAT_EN for the accumulate expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sumador_acumulador;
    import sumador_pkg::*;

    localparam int WIDTH = 4;
    localparam int ACC_W = 8;
    localparam int MAXV  = 127;
    localparam int MINV  = -128;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] c;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pushed = 0;
    int n_popped = 0;
    logic [ACC_W-1:0] exp_q[$];
    int   m_acc = 0;
    logic m_ovf = 1'b0;

    always #5 clk = ~clk;

    sumador_acumulador #(
        .WIDTH     (WIDTH),
        .ACC_W     (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .acc       (acc),
        .ovf       (ovf)
    );

    task automatic check(input string name, input logic [ACC_W-1:0] act,
                         input logic [ACC_W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Waits for the current request to be accepted, then queues its result.
    task automatic wait_accept(input logic [ACC_W-1:0] expc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(expc);
                n_pushed++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check("accept_within_budget", ACC_W'(done), 8'd1);
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic send(input logic [1:0] o, input int av, input int bv,
                        input logic cl, input logic [ACC_W-1:0] expc);
        op       = o;
        a        = WIDTH'(av);
        b        = WIDTH'(bv);
        clr      = cl;
        in_valid = 1'b1;
        wait_accept(expc);
    endtask

    // Accumulate op with its expected result from an integer-range model.
    task automatic acc_op(input logic sub, input int av, input logic do_clr);
        int   r;
        logic ov;
        r  = (do_clr ? 0 : m_acc);
        r  = sub ? (r - av) : (r + av);
        ov = (r > MAXV) || (r < MINV);
`ifdef SUMADOR_ACUMULADOR_SAT_EN
        if (r > MAXV) r = MAXV;
        else if (r < MINV) r = MINV;
`else
        if (r > MAXV) r = r - 256;
        else if (r < MINV) r = r + 256;
`endif
        m_ovf = ((do_clr ? 1'b0 : m_ovf) || ov);
        m_acc = r;
        send(sub ? OP_ACC_SUB : OP_ACC_ADD, av, 0, do_clr, ACC_W'(r));
    endtask

    // Monitor: every consumed output is compared with the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                n_popped++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h, expected none", c);
                end else begin
                    check("c_scoreboard", c, exp_q.pop_front());
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
        op = OP_ADD; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", ACC_W'(out_valid), 8'd0);
        check("rst_c",         c,                 8'd0);
        check("rst_acc",       acc,               8'd0);
        check("rst_ovf",       ACC_W'(ovf),       8'd0);
        check("rst_in_ready",  ACC_W'(in_ready),  8'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Plain add, then registered-result side effects.
        send(OP_ADD, 7, 1, 1'b0, 8'd8);
        check("add_out_valid", ACC_W'(out_valid), 8'd1);
        check("add_acc",       acc,               8'd0);
        check("add_ovf",       ACC_W'(ovf),       8'd0);

        // Extremes of the operand range, back to back.
        send(OP_SUB, -8, 7,  1'b0, 8'hF1);
        send(OP_ADD, -8, -8, 1'b0, 8'hF0);

        // Stall: output held, nothing accepted.
        out_ready = 1'b0;
        op = OP_ADD; a = 4'd3; b = 4'd4; clr = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready",  ACC_W'(in_ready),  8'd0);
            check("stall_c",         c,                 8'hF0);
            check("stall_out_valid", ACC_W'(out_valid), 8'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_accept(8'd7);
        send(OP_ADD, 1, 1, 1'b0, 8'd2);
        send(OP_SUB, 0, 1, 1'b0, 8'hFF);

        // Accumulate 7 nineteen times: overflows on the last step.
        for (int i = 0; i < 19; i++) acc_op(1'b0, 7, 1'b0);
`ifdef SUMADOR_ACUMULADOR_SAT_EN
        check("acc19_acc", acc, 8'd127);
`else
        check("acc19_acc", acc, 8'h85);
`endif
        check("acc19_ovf", ACC_W'(ovf), 8'd1);

        // Steer the accumulator to 100 while keeping the sticky flag.
        for (int i = 0; i < 4; i++) acc_op(1'b0, -8, 1'b0);
`ifdef SUMADOR_ACUMULADOR_SAT_EN
        acc_op(1'b0, 5, 1'b0);
`else
        acc_op(1'b0, -1, 1'b0);
`endif
        check("acc100_acc", acc, 8'd100);
        check("acc100_ovf", ACC_W'(ovf), 8'd1);
        check("acc100_ovf_model", ACC_W'(ovf), ACC_W'(m_ovf));

        // Clear together with an accepted accumulate.
        acc_op(1'b0, 3, 1'b1);
        check("clracc_acc", acc, 8'd3);
        check("clracc_ovf", ACC_W'(ovf), 8'd0);

        // Subtracting the most negative operand.
        acc_op(1'b1, -8, 1'b0);
        check("accsub_min_acc", acc, 8'd11);

        // Clear without accept: acc drops, c holds.
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_only_acc", acc, 8'd0);
        check("clr_only_c",   c,   8'd11);

        // Leave a result stuck in the output stage, then reset asynchronously.
        out_ready = 1'b0;
        acc_op(1'b0, 5, 1'b0);
        check("pre_rst_acc", acc, 8'd5);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", ACC_W'(out_valid), 8'd0);
        check("async_rst_c",         c,                 8'd0);
        check("async_rst_acc",       acc,               8'd0);
        check("async_rst_ovf",       ACC_W'(ovf),       8'd0);
        n_pushed = n_pushed - exp_q.size();
        exp_q.delete();
        m_acc = 0;
        m_ovf = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(OP_ADD, 1, 2, 1'b0, 8'd3);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", ACC_W'(exp_q.size()), 8'd0);
        check("in_out_count",  ACC_W'(n_popped),     ACC_W'(n_pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sumador_acumulador
`default_nettype wire
